// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - two-requester VRAM arbiter (display fetch vs CPU) with starvation guard
module vram_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 12,
   parameter int STARVE_MAX = 15
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iBlank,
   input  logic              iDispReq,
   input  logic [ADDR_W-1:0] iDispAddr,
   output logic              oDispReady,
   output logic [DATA_W-1:0] oDispData,
   output logic              oDispValid,
   input  logic              iCpuReq,
   input  logic              iCpuWe,
   input  logic [ADDR_W-1:0] iCpuAddr,
   input  logic [DATA_W-1:0] iCpuWData,
   output logic              oCpuReady,
   output logic [DATA_W-1:0] oCpuRData,
   output logic              oCpuRValid,
   output logic [ADDR_W-1:0] oRamAddr,
   output logic              oRamWe,
   output logic [DATA_W-1:0] oRamWData,
   input  logic [DATA_W-1:0] iRamRData
);

   typedef enum logic {DISP_PRI, CPU_PRI} pri_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_DISP_RD, TAG_CPU_RD} tag_t;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   pri_t       state, state_next;
   logic [7:0] starve, starve_next;
   tag_t       tag0, tag1;
   logic       disp_xfer, cpu_xfer;

   always_comb begin
      oDispReady = 1'b0;
      oCpuReady  = 1'b0;
      if (Reset) begin
         if (state == DISP_PRI) begin
            oDispReady = 1'b1;
            oCpuReady  = ~iDispReq;
         end else begin
            oCpuReady  = 1'b1;
            oDispReady = ~iCpuReq;
         end
      end
   end

   assign disp_xfer = iDispReq & oDispReady;
   assign cpu_xfer  = iCpuReq & oCpuReady;

   // Switching when the counter reaches the limit on this edge lets the CPU win
   // after exactly STARVE_MAX lost edges rather than STARVE_MAX+1.
   always_comb begin
      starve_next = starve;
      state_next  = state;
      if (!iCpuReq || cpu_xfer)
         starve_next = 8'd0;
      else if (starve != STARVE_LIM)
         starve_next = starve + 8'd1;
      case (state)
         DISP_PRI: if (iBlank || (starve_next == STARVE_LIM && iCpuReq && !cpu_xfer))
                      state_next = CPU_PRI;
         CPU_PRI:  if (!iBlank && (cpu_xfer || !iCpuReq))
                      state_next = DISP_PRI;
         default:  state_next = DISP_PRI;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state      <= DISP_PRI;
         starve     <= 8'd0;
         tag0       <= TAG_NONE;
         tag1       <= TAG_NONE;
         oRamAddr   <= '0;
         oRamWe     <= 1'b0;
         oRamWData  <= '0;
         oDispData  <= '0;
         oDispValid <= 1'b0;
         oCpuRData  <= '0;
         oCpuRValid <= 1'b0;
      end else begin
         state  <= state_next;
         starve <= starve_next;
         oRamWe <= cpu_xfer & iCpuWe;
         if (disp_xfer) begin
            oRamAddr <= iDispAddr;
         end else if (cpu_xfer) begin
            oRamAddr  <= iCpuAddr;
            oRamWData <= iCpuWData;
         end
         // Tags follow the synchronous RAM latency so returned data is steered in acceptance order
         if (disp_xfer)
            tag0 <= TAG_DISP_RD;
         else if (cpu_xfer && !iCpuWe)
            tag0 <= TAG_CPU_RD;
         else
            tag0 <= TAG_NONE;
         tag1       <= tag0;
         oDispValid <= (tag1 == TAG_DISP_RD);
         oCpuRValid <= (tag1 == TAG_CPU_RD);
         if (tag1 == TAG_DISP_RD)
            oDispData <= iRamRData;
         if (tag1 == TAG_CPU_RD)
            oCpuRData <= iRamRData;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter
module tb_vram_arbiter;

   logic        Clock = 1'b0;
   logic        Reset, iBlank, iDispReq, iCpuReq, iCpuWe;
   logic [15:0] iDispAddr, iCpuAddr;
   logic [11:0] iCpuWData, iRamRData;
   logic        oDispReady, oDispValid, oCpuReady, oCpuRValid, oRamWe;
   logic [11:0] oDispData, oCpuRData, oRamWData;
   logic [15:0] oRamAddr;

   always #5 Clock = ~Clock;

   vram_arbiter #(.ADDR_W(16), .DATA_W(12), .STARVE_MAX(15)) dut (
      .Clock(Clock), .Reset(Reset), .iBlank(iBlank),
      .iDispReq(iDispReq), .iDispAddr(iDispAddr), .oDispReady(oDispReady),
      .oDispData(oDispData), .oDispValid(oDispValid),
      .iCpuReq(iCpuReq), .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuWData(iCpuWData),
      .oCpuReady(oCpuReady), .oCpuRData(oCpuRData), .oCpuRValid(oCpuRValid),
      .oRamAddr(oRamAddr), .oRamWe(oRamWe), .oRamWData(oRamWData), .iRamRData(iRamRData)
   );

   typedef struct {
      bit          is_cpu;
      logic [11:0] data;
      int          cyc;
   } sb_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          disp_vcnt = 0;
   int          cpu_vcnt  = 0;
   int          we_cnt    = 0;
   logic [11:0] mem    [65536];
   logic [11:0] shadow [65536];
   sb_t         sb [$];
   byte         xlog [$];
   logic [15:0] exp_addr  = '0;
   logic        exp_we    = 1'b0;
   logic [11:0] exp_wdata = '0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write-first synchronous VRAM
   always @(posedge Clock) begin
      cyc <= cyc + 1;
      if (oRamWe) mem[oRamAddr] <= oRamWData;
      iRamRData <= oRamWe ? oRamWData : mem[oRamAddr];
   end

   task automatic sb_pop(bit is_cpu, logic [11:0] data);
      sb_t e;
      if (sb.size() == 0) begin
         check(is_cpu ? "cpu_unexpected_valid" : "disp_unexpected_valid", 1, 0);
         return;
      end
      e = sb.pop_front();
      check(is_cpu ? "cpu_return_order" : "disp_return_order", 32'(is_cpu), 32'(e.is_cpu));
      check(is_cpu ? "cpu_rdata" : "disp_data", data, e.data);
      check("read_latency", cyc - e.cyc, 3);
   endtask

   always @(negedge Clock) begin
      if (!Reset) begin
         exp_addr  = '0;
         exp_we    = 1'b0;
         exp_wdata = '0;
      end else begin
         check("ram_addr", oRamAddr, exp_addr);
         check("ram_we", oRamWe, exp_we);
         check("ram_wdata", oRamWData, exp_wdata);
         if (oRamWe) we_cnt++;
         if (oDispValid) begin
            disp_vcnt++;
            sb_pop(1'b0, oDispData);
         end
         if (oCpuRValid) begin
            cpu_vcnt++;
            sb_pop(1'b1, oCpuRData);
         end
         check("single_xfer", (iDispReq && oDispReady) && (iCpuReq && oCpuReady), 0);
         exp_we = 1'b0;
         if (iDispReq && oDispReady) begin
            exp_addr = iDispAddr;
            sb.push_back('{1'b0, shadow[iDispAddr], cyc});
            xlog.push_back("D");
         end else if (iCpuReq && oCpuReady) begin
            exp_addr  = iCpuAddr;
            exp_we    = iCpuWe;
            exp_wdata = iCpuWData;
            if (iCpuWe) shadow[iCpuAddr] = iCpuWData;
            else        sb.push_back('{1'b1, shadow[iCpuAddr], cyc});
            xlog.push_back("C");
         end
      end
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic apply_reset();
      Reset    = 1'b0;
      iDispReq = 1'b1;
      iCpuReq  = 1'b1;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      sb.delete();
      check("rst_disp_ready", oDispReady, 0);
      check("rst_cpu_ready", oCpuReady, 0);
      check("rst_ram_addr", oRamAddr, 0);
      check("rst_ram_we", oRamWe, 0);
      check("rst_ram_wdata", oRamWData, 0);
      check("rst_disp_valid", oDispValid, 0);
      check("rst_cpu_valid", oCpuRValid, 0);
      check("rst_disp_data", oDispData, 0);
      check("rst_cpu_rdata", oCpuRData, 0);
      iDispReq = 1'b0;
      iCpuReq  = 1'b0;
      step();
      Reset = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge Clock);
      check("scoreboard_drain", sb.size(), 0);
      step();
   endtask

   task automatic check_log(string tag, string exp);
      check({tag, "_len"}, xlog.size(), exp.len());
      for (int i = 0; i < exp.len() && i < xlog.size(); i++)
         check(tag, xlog[i], exp[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int    v0, c0;
      bit    got;
      string exp_s;
      for (int i = 0; i < 65536; i++) begin
         mem[i]    = 12'(i * 37 + 5);
         shadow[i] = mem[i];
      end
      Reset = 1'b0; iBlank = 1'b0; iDispReq = 1'b0; iCpuReq = 1'b0; iCpuWe = 1'b0;
      iDispAddr = '0; iCpuAddr = '0; iCpuWData = '0;
      #1;
      apply_reset();

      // Display read of 0x0010 returning 0xABC
      mem[16] = 12'hABC; shadow[16] = 12'hABC;
      c0 = cpu_vcnt;
      iDispReq = 1'b1; iDispAddr = 16'h0010; step(); iDispReq = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         if (oDispValid) begin
            got = 1'b1;
            check("disp_abc", oDispData, 12'hABC);
            break;
         end
      end
      check("disp_valid_seen", got, 1);
      drain();
      check("no_cpu_valid_on_disp", cpu_vcnt - c0, 0);

      // CPU write then read-after-write to the same address
      we_cnt = 0;
      iCpuReq = 1'b1; iCpuWe = 1'b1; iCpuAddr = 16'h1234; iCpuWData = 12'h5A5; step();
      iCpuWe = 1'b0; step();
      iCpuReq = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         if (oCpuRValid) begin
            got = 1'b1;
            check("raw_rdata", oCpuRData, 12'h5A5);
            break;
         end
      end
      check("raw_valid_seen", got, 1);
      drain();
      check("we_pulses", we_cnt, 1);

      // Reset one cycle after a display read is accepted
      iDispReq = 1'b1; iDispAddr = 16'h0010; step(); iDispReq = 1'b0;
      v0 = disp_vcnt;
      apply_reset();
      repeat (6) step();
      check("no_valid_after_reset", disp_vcnt - v0, 0);
      iDispReq = 1'b1; iCpuReq = 1'b1; iCpuWe = 1'b0;
      @(negedge Clock);
      check("post_rst_disp_ready", oDispReady, 1);
      check("post_rst_cpu_ready", oCpuReady, 0);
      step();
      iDispReq = 1'b0; iCpuReq = 1'b0;
      drain();

      // Starvation guard: 15 display, 1 CPU, repeating
      apply_reset();
      xlog.delete();
      iDispAddr = 16'h0020; iCpuAddr = 16'h0030; iCpuWe = 1'b0;
      iDispReq = 1'b1; iCpuReq = 1'b1;
      repeat (48) step();
      iDispReq = 1'b0; iCpuReq = 1'b0;
      exp_s = "";
      for (int i = 0; i < 48; i++) exp_s = {exp_s, (i % 16 == 15) ? "C" : "D"};
      check_log("starve_pattern", exp_s);
      drain();

      // Blanking gives the CPU every slot; display only when the CPU is idle
      apply_reset();
      iBlank = 1'b1; step(); step();
      xlog.delete();
      iDispAddr = 16'h0050; iCpuAddr = 16'h0060;
      iDispReq = 1'b1; iCpuReq = 1'b1;
      repeat (10) step();
      iCpuReq = 1'b0;
      repeat (3) step();
      iDispReq = 1'b0; iBlank = 1'b0;
      check_log("blank_pattern", "CCCCCCCCCCDDD");
      drain();

      // Alternating display/CPU reads on consecutive edges
      apply_reset();
      xlog.delete();
      v0 = disp_vcnt; c0 = cpu_vcnt;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            iDispReq = 1'b1; iCpuReq = 1'b0; iDispAddr = 16'(16'h0100 + i);
         end else begin
            iDispReq = 1'b0; iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = 16'(16'h0200 + i);
         end
         step();
      end
      iDispReq = 1'b0; iCpuReq = 1'b0;
      check_log("alt_pattern", "DCDCDCDC");
      drain();
      check("alt_disp_valids", disp_vcnt - v0, 4);
      check("alt_cpu_valids", cpu_vcnt - c0, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: VRAM word address width.
REQ-002 Parameter DATA_W, default 12: pixel word width (4:4:4 RGB).
REQ-003 Parameter STARVE_MAX, default 15: wait cycles before a pending CPU request is forced to priority; legal range 1..255.
REQ-004 Clock  input  1  sole clock; all logic on rising edge.
REQ-005 Reset  input  1  synchronous, active-low reset.
REQ-006 iBlank  input  1  high while the VGA scan is in a blanking interval.
REQ-007 iDispReq  input  1  display fetch read request (valid).
REQ-008 iDispAddr  input  ADDR_W  display fetch address.
REQ-009 oDispReady  output  1  display request accepted this cycle when high with iDispReq.
REQ-010 oDispData  output  DATA_W  display read data.
REQ-011 oDispValid  output  1  one-cycle pulse qualifying oDispData.
REQ-012 iCpuReq  input  1  CPU access request (valid).
REQ-013 iCpuWe  input  1  1 = write, 0 = read.
REQ-014 iCpuAddr  input  ADDR_W  CPU address.
REQ-015 iCpuWData  input  DATA_W  CPU write data.
REQ-016 oCpuReady  output  1  CPU request accepted this cycle when high with iCpuReq.
REQ-017 oCpuRData  output  DATA_W  CPU read data.
REQ-018 oCpuRValid  output  1  one-cycle pulse qualifying oCpuRData.
REQ-019 oRamAddr  output  ADDR_W  registered VRAM address.
REQ-020 oRamWe  output  1  registered VRAM write enable.
REQ-021 oRamWData  output  DATA_W  registered VRAM write data.
REQ-022 iRamRData  input  DATA_W  VRAM read data, one cycle after oRamAddr (synchronous RAM).

Function
REQ-023 Transfer occurs on a rising edge where Req and Ready are both high; at most one transfer per edge.
REQ-024 Requesters hold Req and payload stable until accepted; a Req still high after a transfer edge is a new request.
REQ-025 Priority FSM has two states, DISP_PRI and CPU_PRI.
REQ-026 DISP_PRI: oDispReady = 1; oCpuReady = ~iDispReq.
REQ-027 CPU_PRI: oCpuReady = 1; oDispReady = ~iCpuReq.
REQ-028 Ready outputs are combinational from FSM state and the current Req inputs only; no dependence on payload.
REQ-029 Starve counter, 8 bits: increments on each edge with iCpuReq=1 and no CPU transfer, saturates at STARVE_MAX, clears on a CPU transfer or when iCpuReq=0.
REQ-030 DISP_PRI -> CPU_PRI on the edge where iBlank=1, or where the starve counter equals STARVE_MAX and iCpuReq=1 with no CPU transfer.
REQ-031 CPU_PRI -> DISP_PRI on the edge where iBlank=0 and a CPU transfer occurs, or where iBlank=0 and iCpuReq=0.
REQ-032 On a transfer edge N, oRamAddr/oRamWe/oRamWData are updated with the accepted payload; oRamWe=1 only for an accepted CPU write.
REQ-033 With no transfer, oRamWe = 0 and oRamAddr holds its previous value.
REQ-034 A 2-stage tag pipeline (NONE, DISP_RD, CPU_RD) tracks each transfer; CPU writes tag NONE.
REQ-035 For a read accepted at edge N, iRamRData is captured at edge N+2 into oDispData or oCpuRData, with the matching Valid high for the cycle following edge N+2.
REQ-036 Back-to-back reads return in acceptance order, one Valid per read, no gaps inserted.
REQ-037 oDispData/oCpuRData hold their last value when the corresponding Valid is low.
REQ-038 A CPU write followed by a CPU read to the same address on the next edge returns the written data (RAM write-first behaviour required of VRAM).

Reset
REQ-039 Reset=0 at an edge: FSM -> DISP_PRI; starve counter, both pipeline tags, oRamAddr, oRamWData, oDispData and oCpuRData -> 0; oRamWe, oDispValid and oCpuRValid -> 0.
REQ-040 While Reset=0, oDispReady = oCpuReady = 0 and no transfer occurs.
REQ-041 Reads in flight at reset are discarded; no Valid pulse for them after reset release.

Verification
REQ-042 Both Req held high, iBlank=0, STARVE_MAX=15 -> 15 display transfers, then exactly one CPU transfer, then display resumes; pattern repeats.
REQ-043 iBlank=1, both Req high -> every transfer is CPU; display transfers only when iCpuReq=0.
REQ-044 Display read addr 0x0010 accepted at edge N, RAM returns 0xABC -> oDispValid high in cycle after N+2, oDispData=0xABC, oCpuRValid stays 0.
REQ-045 CPU write 0x5A5 to 0x1234, next-edge CPU read 0x1234 -> oRamWe pulses once, oCpuRData=0x5A5 two cycles after the read acceptance.
REQ-046 Reset=0 asserted one cycle after a display read is accepted -> no oDispValid afterwards, all outputs 0, FSM in DISP_PRI after release.
REQ-047 Alternating display/CPU reads on consecutive edges -> Valid pulses alternate in the same order with correct data, no dropped or duplicated returns.
